mod_exp_engine: RTL and testbench

// - Computes result = base^e mod n for Pollard p-1: consumes e (65-bit prime-power product)

---
 rtl/pm1_pkg.sv | 18 +
 rtl/mod_mul.sv | 72 +++++++
 rtl/mod_exp_engine.sv | 144 ++++++++++++++
 tb/tb_mod_exp_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pm1_pkg.sv
// Shared widths and FSM state encoding for the Pollard p-1 pipeline
// (e_finder, mod_exp_engine, gcd stage).
package pm1_pkg;
   localparam int unsigned W    = 32;
   localparam int unsigned EW   = 65;
   localparam int unsigned IDXW = $clog2(EW);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      REDUCE,
      SCAN,
      NEXT,
      SQUARE,
      MULT,
      DONE
   } state_t;
endpackage

// File: rtl/mod_mul.sv
// Serial interleaved modular multiplier: p = a*b mod n, MSB-first over a,
// one bit per cycle, done pulses exactly MW+1 cycles after start. Needs b < n.
module mod_mul
   import pm1_pkg::*;
#(
   parameter int unsigned MW = W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [MW-1:0] a,
   input  logic [MW-1:0] b,
   input  logic [MW-1:0] n,
   output logic          busy,
   output logic          done,
   output logic [MW-1:0] p
);
   localparam int unsigned CW = $clog2(MW + 1);

   logic [MW-1:0] r_a;
   logic [MW-1:0] r_b;
   logic [MW-1:0] r_n;
   logic [MW+1:0] r_r;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;

   logic [MW+1:0] w_sum;
   logic [MW+1:0] w_red1;
   logic [MW+1:0] w_red2;

   // 2r + b < 3n, so two conditional subtractions bring it back below n
   always_comb begin
      w_sum  = (r_r << 1) + (r_a[MW-1] ? {2'b00, r_b} : '0);
      w_red1 = (w_sum >= {2'b00, r_n}) ? w_sum - {2'b00, r_n} : w_sum;
      w_red2 = (w_red1 >= {2'b00, r_n}) ? w_red1 - {2'b00, r_n} : w_red1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a    <= '0;
         r_b    <= '0;
         r_n    <= '0;
         r_r    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start && !r_busy) begin
            r_a    <= a;
            r_b    <= b;
            r_n    <= n;
            r_r    <= '0;
            r_cnt  <= CW'(MW);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_r   <= w_red2;
            r_a   <= r_a << 1;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign p    = r_r[MW-1:0];
endmodule

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply: result = base^e mod n, built around a
// single shared mod_mul whose operands are selected by the FSM state.
module mod_exp_engine
   import pm1_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  base,
   input  logic [W-1:0]  n,
   input  logic [EW-1:0] e,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  result,
   output logic          err
);
   state_t          r_state;
   state_t          w_next;
   logic [W-1:0]    r_base;
   logic [W-1:0]    r_n;
   logic [EW-1:0]   r_e;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_acc;
   logic [IDXW-1:0] r_idx;
   logic            r_busy;
   logic            r_done;
   logic [W-1:0]    r_result;
   logic            r_err;

   logic            w_e_bit;
   logic            w_special;
   logic            w_mul_start;
   logic [W-1:0]    w_mul_a;
   logic [W-1:0]    w_mul_b;
   logic            w_mul_busy;
   logic            w_mul_done;
   logic [W-1:0]    w_mul_p;

   assign w_e_bit   = r_e[r_idx];
   assign w_special = (r_n == '0) || (r_n == W'(1)) || (r_e == '0);

   mod_mul #(.MW(W)) u_mod_mul (
      .clk   (clk),
      .reset (reset),
      .start (w_mul_start),
      .a     (w_mul_a),
      .b     (w_mul_b),
      .n     (r_n),
      .busy  (w_mul_busy),
      .done  (w_mul_done),
      .p     (w_mul_p)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Multiply states fire mod_mul on their first cycle and leave on its done
   always_comb begin
      w_next      = r_state;
      w_mul_start = 1'b0;
      w_mul_a     = r_acc;
      w_mul_b     = r_acc;
      case (r_state)
         IDLE:   if (start) w_next = CHECK;
         CHECK:  w_next = w_special ? DONE : REDUCE;
         REDUCE: begin
            w_mul_a     = r_base;
            w_mul_b     = W'(1);
            w_mul_start = !w_mul_busy && !w_mul_done;
            if (w_mul_done) w_next = SCAN;
         end
         SCAN:   if (w_e_bit) w_next = NEXT;
         NEXT:   w_next = (r_idx == '0) ? DONE : SQUARE;
         SQUARE: begin
            w_mul_start = !w_mul_busy && !w_mul_done;
            if (w_mul_done) w_next = w_e_bit ? MULT : NEXT;
         end
         MULT: begin
            w_mul_b     = r_b;
            w_mul_start = !w_mul_busy && !w_mul_done;
            if (w_mul_done) w_next = NEXT;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_base   <= '0;
         r_n      <= '0;
         r_e      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_idx    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_base <= base;
               r_n    <= n;
               r_e    <= e;
               r_err  <= 1'b0;
               r_busy <= 1'b1;
            end
            CHECK: begin
               r_idx <= IDXW'(EW - 1);
               if (w_special) begin
                  r_done   <= 1'b1;
                  r_err    <= (r_n == '0);
                  r_result <= (r_n > W'(1)) ? W'(1) : '0;
               end
            end
            REDUCE: if (w_mul_done) r_b <= w_mul_p;
            SCAN: begin
               if (w_e_bit) r_acc <= r_b;
               else         r_idx <= r_idx - IDXW'(1);
            end
            NEXT: begin
               if (r_idx == '0) begin
                  r_result <= r_acc;
                  r_done   <= 1'b1;
               end else begin
                  r_idx <= r_idx - IDXW'(1);
               end
            end
            SQUARE, MULT: if (w_mul_done) r_acc <= w_mul_p;
            DONE: r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign err    = r_err;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine against a right-to-left modpow model.
module tb_mod_exp_engine;
   import pm1_pkg::*;

   localparam int TMO = 20000;

   logic          clk;
   logic          reset;
   logic          start;
   logic [31:0]   base;
   logic [31:0]   n;
   logic [64:0]   e;
   logic          busy;
   logic          done;
   logic [31:0]   result;
   logic          err;

   int checks   = 0;
   int failures = 0;

   mod_exp_engine dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .base   (base),
      .n      (n),
      .e      (e),
      .busy   (busy),
      .done   (done),
      .result (result),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] nn,
                                           input logic [64:0] ee);
      longint unsigned m, x, r;
      if (nn < 32'd2) return 32'd0;
      m = longint'(nn);
      x = longint'(b) % m;
      r = 1;
      for (int i = 0; i < 65; i++) begin
         if (ee[i]) r = (r * x) % m;
         x = (x * x) % m;
      end
      return r[31:0];
   endfunction

   // Product of the largest prime powers <= bound, kept within 65 bits
   function automatic logic [64:0] efinder_e(input int bound);
      logic [129:0] prod;
      prod = 130'd1;
      for (int p = 2; p <= bound; p++) begin
         bit prime;
         int pk;
         prime = 1'b1;
         for (int d = 2; d * d <= p; d++) if (p % d == 0) prime = 1'b0;
         if (prime) begin
            pk = p;
            while (pk * p <= bound) pk = pk * p;
            if ((prod * 130'(pk)) < (130'd1 << 65)) prod = prod * 130'(pk);
         end
      end
      return 65'(prod);
   endfunction

   task automatic do_op(input logic [31:0] b, input logic [31:0] nn, input logic [64:0] ee,
                        output logic [31:0] res, output logic er, output int cyc,
                        output bit to);
      @(posedge clk); #1;
      base = b; n = nn; e = ee; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base = $urandom; n = $urandom; e = 65'({$urandom, $urandom, $urandom});
      cyc = 1;
      while (done !== 1'b1 && cyc < TMO) begin
         @(posedge clk); #1;
         cyc++;
      end
      to  = (done !== 1'b1);
      res = result;
      er  = err;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; base = '0; n = '0; e = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== 32'd0)  begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
      checks++; if (err !== 1'b0)      begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
   endtask

   task automatic test_vectors();
      logic [31:0] tb_b [3] = '{32'd2, 32'd2, 32'd20};
      logic [31:0] tb_n [3] = '{32'd299, 32'd1000, 32'd7};
      logic [64:0] tb_e [3] = '{65'd60, 65'd10, 65'd1};
      logic [31:0] tb_r [3] = '{32'd170, 32'd24, 32'd6};
      logic [31:0] res; logic er; int cyc; bit to;
      for (int i = 0; i < 3; i++) begin
         do_op(tb_b[i], tb_n[i], tb_e[i], res, er, cyc, to);
         checks++; if (to)             begin failures++; $display("FAIL vec%0d_timeout cycles=%0d", i, cyc); end
         checks++; if (res !== tb_r[i]) begin failures++; $display("FAIL vec%0d_result got=%0d exp=%0d", i, res, tb_r[i]); end
         checks++; if (er !== 1'b0)    begin failures++; $display("FAIL vec%0d_err got=%b exp=0", i, er); end
      end
   endtask

   task automatic test_special();
      logic [31:0] tb_n [3] = '{32'd13, 32'd1, 32'd0};
      logic [64:0] tb_e [3] = '{65'd0, 65'd7, 65'd7};
      logic [31:0] tb_r [3] = '{32'd1, 32'd0, 32'd0};
      logic        tb_x [3] = '{1'b0, 1'b0, 1'b1};
      logic [31:0] res; logic er; int cyc; bit to;
      for (int i = 0; i < 3; i++) begin
         do_op(32'd5, tb_n[i], tb_e[i], res, er, cyc, to);
         checks++; if (to || cyc > 3)  begin failures++; $display("FAIL special%0d_latency got=%0d exp<=3", i, cyc); end
         checks++; if (res !== tb_r[i]) begin failures++; $display("FAIL special%0d_result got=%0d exp=%0d", i, res, tb_r[i]); end
         checks++; if (er !== tb_x[i])  begin failures++; $display("FAIL special%0d_err got=%b exp=%b", i, er, tb_x[i]); end
      end
   endtask

   task automatic test_busy_start();
      int ndone; logic [31:0] res1; logic er1;
      @(posedge clk); #1;
      base = 32'd3; n = 32'd7; e = 65'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b exp=1", busy); end
      ndone = 0; res1 = '0; er1 = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (c == 40) begin base = 32'd2; n = 32'd299; e = 65'd60; start = 1'b1; end
         if (c == 41) start = 1'b0;
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin res1 = result; er1 = err; end
         end
         @(posedge clk); #1;
      end
      checks++; if (ndone != 1)      begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", ndone); end
      checks++; if (res1 !== 32'd4)  begin failures++; $display("FAIL busy_start_result got=%0d exp=4", res1); end
      checks++; if (er1 !== 1'b0)    begin failures++; $display("FAIL busy_start_err got=%b exp=0", er1); end
   endtask

   task automatic test_reset_mid();
      int c; int ndone; logic [31:0] res; logic er; int cyc; bit to;
      @(posedge clk); #1;
      base = 32'd2; n = 32'd299; e = 65'd60; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      while (dut.r_state != SQUARE && c < 2000) begin @(posedge clk); #1; c++; end
      checks++; if (dut.r_state != SQUARE) begin failures++; $display("FAIL reach_square cycles=%0d", c); end
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
      checks++; if (result !== 32'd0) begin failures++; $display("FAIL midreset_result got=%0d exp=0", result); end
      ndone = 0;
      for (int k = 0; k < 200; k++) begin
         if (done === 1'b1) ndone++;
         @(posedge clk); #1;
      end
      checks++; if (ndone != 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", ndone); end
      do_op(32'd2, 32'd299, 65'd60, res, er, cyc, to);
      checks++; if (to || res !== 32'd170) begin failures++; $display("FAIL midreset_rerun got=%0d exp=170", res); end
   endtask

   task automatic test_random();
      logic [31:0] rb, rn, exp_r, res; logic [64:0] re; logic er; int cyc; bit to;
      for (int i = 0; i < 8; i++) begin
         rb = $urandom;
         rn = $urandom;
         if (i == 2) rn = 32'd2;
         if (i == 5) rn = 32'd1;
         re = 65'({$urandom, $urandom, $urandom});
         if (i == 3) re = 65'(1) << 64;
         exp_r = ref_pow(rb, rn, re);
         do_op(rb, rn, re, res, er, cyc, to);
         checks++;
         if (to || res !== exp_r || er !== 1'b0) begin
            failures++;
            $display("FAIL random%0d b=%0d n=%0d got=%0d/%b exp=%0d/0", i, rb, rn, res, er, exp_r);
         end
      end
   endtask

   task automatic test_chained();
      logic [64:0] ee; logic [31:0] exp_r, res, held; logic er; int cyc; bit to; int stable;
      ee    = efinder_e(100);
      exp_r = ref_pow(32'd2, 32'hFFFF_FFFB, ee);
      do_op(32'd2, 32'hFFFF_FFFB, ee, res, er, cyc, to);
      checks++; if (to || res !== exp_r) begin failures++; $display("FAIL chained_result got=%0d exp=%0d", res, exp_r); end
      checks++; if (er !== 1'b0)         begin failures++; $display("FAIL chained_err got=%b exp=0", er); end
      // start raised during the done cycle must be ignored
      held = result;
      base = 32'd3; n = 32'd7; e = 65'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_in_done_ignored busy=%b exp=0", busy); end
      stable = 1;
      for (int k = 0; k < 20; k++) begin
         if (result !== held || busy !== 1'b0) stable = 0;
         @(posedge clk); #1;
      end
      checks++; if (stable != 1) begin failures++; $display("FAIL result_hold got=%0d exp=%0d", result, held); end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_special();
      test_busy_start();
      test_reset_mid();
      test_random();
      test_chained();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
